// File: rtl/me_pkg.sv
// me_pkg -- shared definitions for the memory stage.
// Holds the memory opcode and funct3 encodings, the access FSM state type,
// the M-register beat count and small helpers that classify an opcode and
// build the store byte-enable / store data replication.
package me_pkg;

  // An M register is 512 bits, moved as 16 32-bit beats.
  localparam int M_BEATS = 16;
  localparam int BEAT_W  = $clog2(M_BEATS);

  // Memory opcodes; every other opcode passes straight through the stage.
  localparam logic [6:0] OP_LOAD_R  = 7'b0000011;
  localparam logic [6:0] OP_STORE_R = 7'b0100011;
  localparam logic [6:0] OP_LOAD_F  = 7'b0000111;
  localparam logic [6:0] OP_STORE_F = 7'b0100111;
  localparam logic [6:0] OP_LOAD_M  = 7'b0001011;
  localparam logic [6:0] OP_STORE_M = 7'b0101011;

  // Scalar access size / extension encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } me_state_e;

  // Which register file a memory op targets (CLS_PASS = not a memory op).
  typedef enum logic [1:0] {
    CLS_PASS,
    CLS_R,
    CLS_F,
    CLS_M
  } mem_class_e;

  typedef struct packed {
    mem_class_e cls;
    logic       store;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [6:0] opcode);
    mem_op_t op;
    op.cls   = CLS_PASS;
    op.store = 1'b0;
    case (opcode)
      OP_LOAD_R:  op.cls = CLS_R;
      OP_STORE_R: begin op.cls = CLS_R; op.store = 1'b1; end
      OP_LOAD_F:  op.cls = CLS_F;
      OP_STORE_F: begin op.cls = CLS_F; op.store = 1'b1; end
      OP_LOAD_M:  op.cls = CLS_M;
      OP_STORE_M: begin op.cls = CLS_M; op.store = 1'b1; end
      default:    op.cls = CLS_PASS;
    endcase
    return op;
  endfunction

  // Byte lanes written by a scalar store; halfwords ignore addr[0].
  function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (funct3)
      F3_B:    mask = 4'b0001 << addr_lo;
      F3_H:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Stores put the datum on every lane so the mask alone picks the target.
  function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                             input logic [31:0] data);
    logic [31:0] word;
    case (funct3)
      F3_B:    word = {4{data[7:0]}};
      F3_H:    word = {2{data[15:0]}};
      default: word = data;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/me_load_align.sv
// me_load_align -- combinational load data extraction.
// Picks the addressed byte / halfword out of the returned memory word and
// sign- or zero-extends it according to funct3.
//   mem_rdata  in  32  word returned by memory
//   addr_lo    in  2   low address bits of the access
//   funct3     in  3   access size / signedness
//   data       out 32  aligned, extended load result
module me_load_align
  import me_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data     = mem_rdata;

    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase

    // Halfword lane comes from addr[1] only; a misaligned addr[0] is ignored.
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      F3_W:    data = mem_rdata;
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/me_stage.sv
// me_stage -- pipeline memory stage.
// Accepts one instruction at a time from EX. Non-memory ops go straight to
// the result register; loads/stores run a request/wait handshake with
// memory (16 beats for M registers) before the result is presented to WB.
//   clk, rst                 clock, asynchronous active-low reset
//   EX_valid / ready         upstream handshake
//   valid / WB_ready         downstream handshake
//   opcode..rs2_M            instruction payload from EX
//   mem_*                    single-outstanding memory port
//   wb_*                     registered result towards WB
module me_stage
  import me_pkg::*;
(
  input  logic         clk,
  input  logic         rst,

  input  logic         EX_valid,
  output logic         ready,
  input  logic         WB_ready,
  output logic         valid,

  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [1:0]   rd_group,
  input  logic [4:0]   rd_index,
  input  logic         pc_opt,
  input  logic [31:0]  npc,
  input  logic [31:0]  res_R,
  input  logic [31:0]  res_F,
  input  logic [511:0] res_M,
  input  logic [31:0]  rs2_R,
  input  logic [31:0]  rs2_F,
  input  logic [511:0] rs2_M,

  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wmask,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,

  output logic [1:0]   wb_rd_group,
  output logic [4:0]   wb_rd_index,
  output logic         wb_pc_opt,
  output logic [31:0]  wb_npc,
  output logic [31:0]  wb_R,
  output logic [31:0]  wb_F,
  output logic [511:0] wb_M
);

  me_state_e         state;
  me_state_e         state_next;
  logic [BEAT_W-1:0] beat;

  // Payload captured at acceptance of a memory op, held for the whole access.
  mem_op_t           op;
  logic [2:0]        op_f3;
  logic [31:0]       op_addr;
  logic [511:0]      op_wsrc;
  logic [1:0]        op_rd_group;
  logic [4:0]        op_rd_index;
  logic              op_pc_opt;
  logic [31:0]       op_npc;
  logic [31:0]       op_res_R;
  logic [31:0]       op_res_F;
  logic [511:0]      op_res_M;

  mem_op_t           in_op;
  logic              in_is_mem;
  logic              accept;
  logic              in_req;
  logic              last_beat;
  logic              beat_done;
  logic              done;
  logic              m_load;
  logic [31:0]       load_word;
  logic [31:0]       beat_wdata;

  assign in_op     = decode_op(opcode);
  assign in_is_mem = (in_op.cls != CLS_PASS);

  assign ready  = (state == ST_IDLE) && (!valid || WB_ready);
  assign accept = EX_valid && ready;

  assign last_beat = (op.cls != CLS_M) || (beat == BEAT_W'(M_BEATS - 1));
  // mem_rvalid only counts while an access is waiting; strays are dropped.
  assign beat_done = (state == ST_WAIT) && mem_rvalid;
  assign done      = beat_done && last_beat;
  assign m_load    = (op.cls == CLS_M) && !op.store;

  me_load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (op_addr[1:0]),
    .funct3    (op_f3),
    .data      (load_word)
  );

  // Memory port is driven only in REQ so it reads all-zero otherwise; the
  // captured payload cannot change in REQ, which keeps it stable until gnt.
  assign in_req     = (state == ST_REQ);
  assign beat_wdata = (op.cls == CLS_M) ? op_wsrc[{beat, 5'b00000} +: 32]
                                        : store_data(op_f3, op_wsrc[31:0]);
  assign mem_req    = in_req;
  assign mem_we     = in_req && op.store;
  assign mem_addr   = in_req ? ({op_addr[31:2], 2'b00} +
                                {{(30 - BEAT_W){1'b0}}, beat, 2'b00})
                             : 32'h0;
  assign mem_wdata  = (in_req && op.store) ? beat_wdata : 32'h0;
  assign mem_wmask  = (in_req && op.store)
                    ? ((op.cls == CLS_M) ? 4'hF : store_mask(op_f3, op_addr[1:0]))
                    : 4'h0;

  // Access FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Access FSM next state: one request in flight, every beat (stores too)
  // closes with mem_rvalid.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && in_is_mem) state_next = ST_REQ;
      ST_REQ:  if (mem_gnt)             state_next = ST_WAIT;
      ST_WAIT: if (mem_rvalid)          state_next = last_beat ? ST_IDLE : ST_REQ;
      default:                          state_next = ST_IDLE;
    endcase
  end

  // Operand capture and beat counting for memory ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat        <= '0;
      op          <= '{cls: CLS_PASS, store: 1'b0};
      op_f3       <= '0;
      op_addr     <= '0;
      op_wsrc     <= '0;
      op_rd_group <= '0;
      op_rd_index <= '0;
      op_pc_opt   <= 1'b0;
      op_npc      <= '0;
      op_res_R    <= '0;
      op_res_F    <= '0;
      op_res_M    <= '0;
    end else begin
      if (accept && in_is_mem) begin
        beat        <= '0;
        op          <= in_op;
        op_f3       <= funct3;
        op_addr     <= res_R;
        op_rd_group <= rd_group;
        op_rd_index <= rd_index;
        op_pc_opt   <= pc_opt;
        op_npc      <= npc;
        op_res_R    <= res_R;
        op_res_F    <= res_F;
        op_res_M    <= res_M;
        case (in_op.cls)
          CLS_M:   op_wsrc <= rs2_M;
          CLS_F:   op_wsrc <= {480'h0, rs2_F};
          default: op_wsrc <= {480'h0, rs2_R};
        endcase
      end else if (beat_done) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

  // Result register: filled by a pass-through acceptance or by the final
  // beat of a memory op, otherwise drained by WB_ready. M-load beats land in
  // wb_M as they arrive; valid is low during the access so this is unseen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      wb_rd_group <= '0;
      wb_rd_index <= '0;
      wb_pc_opt   <= 1'b0;
      wb_npc      <= '0;
      wb_R        <= '0;
      wb_F        <= '0;
      wb_M        <= '0;
    end else if (accept && !in_is_mem) begin
      valid       <= 1'b1;
      wb_rd_group <= rd_group;
      wb_rd_index <= rd_index;
      wb_pc_opt   <= pc_opt;
      wb_npc      <= npc;
      wb_R        <= res_R;
      wb_F        <= res_F;
      wb_M        <= res_M;
    end else if (done) begin
      valid       <= 1'b1;
      wb_rd_group <= op_rd_group;
      wb_rd_index <= op_rd_index;
      wb_pc_opt   <= op_pc_opt;
      wb_npc      <= op_npc;
      wb_R        <= (op.cls == CLS_R && !op.store) ? load_word : op_res_R;
      wb_F        <= (op.cls == CLS_F && !op.store) ? load_word : op_res_F;
      if (m_load) wb_M[{beat, 5'b00000} +: 32] <= mem_rdata;
      else        wb_M <= op_res_M;
    end else begin
      if (WB_ready) valid <= 1'b0;
      if (beat_done && m_load) wb_M[{beat, 5'b00000} +: 32] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_me_stage.sv
// tb_me_stage -- directed bench for me_stage.
// Scalar loads/stores come from a vector table; pass-through, back-pressure,
// the 16-beat M load and reset in the middle of an M store are hand-written
// sequences. Inputs change 1 time unit after a rising edge.
module tb_me_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         EX_valid = 1'b0;
  logic         ready;
  logic         WB_ready = 1'b0;
  logic         valid;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic [1:0]   rd_group = '0;
  logic [4:0]   rd_index = '0;
  logic         pc_opt = 1'b0;
  logic [31:0]  npc = '0;
  logic [31:0]  res_R = '0;
  logic [31:0]  res_F = '0;
  logic [511:0] res_M = '0;
  logic [31:0]  rs2_R = '0;
  logic [31:0]  rs2_F = '0;
  logic [511:0] rs2_M = '0;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wmask;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic [1:0]   wb_rd_group;
  logic [4:0]   wb_rd_index;
  logic         wb_pc_opt;
  logic [31:0]  wb_npc;
  logic [31:0]  wb_R;
  logic [31:0]  wb_F;
  logic [511:0] wb_M;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_R;
    logic [31:0] rs2_F;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wb_R;
    logic [31:0] exp_wb_F;
  } vec_t;

  vec_t vecs[10];

  me_stage dut (
    .clk        (clk),
    .rst        (rst),
    .EX_valid   (EX_valid),
    .ready      (ready),
    .WB_ready   (WB_ready),
    .valid      (valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd_group   (rd_group),
    .rd_index   (rd_index),
    .pc_opt     (pc_opt),
    .npc        (npc),
    .res_R      (res_R),
    .res_F      (res_F),
    .res_M      (res_M),
    .rs2_R      (rs2_R),
    .rs2_F      (rs2_F),
    .rs2_M      (rs2_M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_rd_group(wb_rd_group),
    .wb_rd_index(wb_rd_index),
    .wb_pc_opt  (wb_pc_opt),
    .wb_npc     (wb_npc),
    .wb_R       (wb_R),
    .wb_F       (wb_F),
    .wb_M       (wb_M)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One scalar memory op with a zero-wait memory.
  task automatic apply_stimulus(input vec_t v, input int i);
    EX_valid   = 1'b1;
    opcode     = v.opcode;
    funct3     = v.funct3;
    res_R      = v.addr;
    res_F      = 32'h0F0F0F0F;
    res_M      = '0;
    rs2_R      = v.rs2_R;
    rs2_F      = v.rs2_F;
    rs2_M      = '0;
    WB_ready   = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_output($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
    next_cycle();
    EX_valid = 1'b0;
    #1;
    check_output($sformatf("v%0d_req", i), 32'(mem_req), 32'd1);
    check_output($sformatf("v%0d_addr", i), mem_addr, v.exp_addr);
    check_output($sformatf("v%0d_we", i), 32'(mem_we), 32'(v.exp_we));
    check_output($sformatf("v%0d_wmask", i), 32'(mem_wmask), 32'(v.exp_wmask));
    if (v.exp_we) check_output($sformatf("v%0d_wdata", i), mem_wdata, v.exp_wdata);
    check_output($sformatf("v%0d_valid_busy", i), 32'(valid), 32'd0);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = v.rdata;
    #1;
    check_output($sformatf("v%0d_req_wait", i), 32'(mem_req), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    check_output($sformatf("v%0d_valid_done", i), 32'(valid), 32'd1);
    check_output($sformatf("v%0d_wb_R", i), wb_R, v.exp_wb_R);
    check_output($sformatf("v%0d_wb_F", i), wb_F, v.exp_wb_F);
  endtask

  initial begin
    // opcode, funct3, addr, rs2_R, rs2_F, rdata, exp_addr, exp_we, exp_wdata, exp_wmask, exp_wb_R, exp_wb_F
    vecs[0] = '{7'b0000011, 3'b000, 32'h1003, 32'h0, 32'h0, 32'h80FFFFFF, 32'h1000, 1'b0, 32'h0, 4'h0, 32'hFFFFFF80, 32'h0F0F0F0F};
    vecs[1] = '{7'b0000011, 3'b100, 32'h1003, 32'h0, 32'h0, 32'h80FFFFFF, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h00000080, 32'h0F0F0F0F};
    vecs[2] = '{7'b0000011, 3'b001, 32'h1006, 32'h0, 32'h0, 32'h80017FFF, 32'h1004, 1'b0, 32'h0, 4'h0, 32'hFFFF8001, 32'h0F0F0F0F};
    vecs[3] = '{7'b0000011, 3'b101, 32'h1005, 32'h0, 32'h0, 32'h8001F00D, 32'h1004, 1'b0, 32'h0, 4'h0, 32'h0000F00D, 32'h0F0F0F0F};
    vecs[4] = '{7'b0000011, 3'b010, 32'h100B, 32'h0, 32'h0, 32'hDEADBEEF, 32'h1008, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0F0F0F0F};
    vecs[5] = '{7'b0100011, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 32'hFFFFFFFF, 32'h2000, 1'b1, 32'hBEEFBEEF, 4'hC, 32'h00002002, 32'h0F0F0F0F};
    vecs[6] = '{7'b0100011, 3'b000, 32'h2001, 32'h000000A5, 32'h0, 32'hFFFFFFFF, 32'h2000, 1'b1, 32'hA5A5A5A5, 4'h2, 32'h00002001, 32'h0F0F0F0F};
    vecs[7] = '{7'b0100011, 3'b010, 32'h2004, 32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, 32'h2004, 1'b1, 32'hCAFEF00D, 4'hF, 32'h00002004, 32'h0F0F0F0F};
    vecs[8] = '{7'b0000111, 3'b010, 32'h3000, 32'h0, 32'h0, 32'h3F800000, 32'h3000, 1'b0, 32'h0, 4'h0, 32'h00003000, 32'h3F800000};
    vecs[9] = '{7'b0100111, 3'b010, 32'h3004, 32'hBAD0BAD0, 32'h40490FDB, 32'hFFFFFFFF, 32'h3004, 1'b1, 32'h40490FDB, 4'hF, 32'h00003004, 32'h0F0F0F0F};

    // Reset state.
    #1 rst = 1'b0;
    #1;
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_wb_R", wb_R, 32'h0);
    check_output("rst_ready", 32'(ready), 32'd1);
    next_cycle();
    next_cycle();

    // Pass-through, presented on the first edge after reset release.
    rst      = 1'b1;
    EX_valid = 1'b1;
    WB_ready = 1'b1;
    opcode   = 7'b0110011;
    res_R    = 32'h12345678;
    res_F    = 32'hA5A5A5A5;
    res_M    = {16{32'hC0DE0000}};
    rd_group = 2'd2;
    rd_index = 5'd7;
    pc_opt   = 1'b1;
    npc      = 32'h80;
    next_cycle();
    EX_valid = 1'b0;
    check_output("pt_valid", 32'(valid), 32'd1);
    check_output("pt_wb_R", wb_R, 32'h12345678);
    check_output("pt_wb_F", wb_F, 32'hA5A5A5A5);
    check_output("pt_wb_M1", wb_M[63:32], 32'hC0DE0000);
    check_output("pt_rd_group", 32'(wb_rd_group), 32'd2);
    check_output("pt_rd_index", 32'(wb_rd_index), 32'd7);
    check_output("pt_pc_opt", 32'(wb_pc_opt), 32'd1);
    check_output("pt_npc", wb_npc, 32'h80);
    check_output("pt_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    check_output("pt_valid_drain", 32'(valid), 32'd0);

    // Scalar memory ops from the table.
    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], i);

    // Back-pressure: A held while WB stalls, B accepted as WB_ready rises.
    next_cycle();
    EX_valid = 1'b1;
    opcode   = 7'b0010011;
    res_R    = 32'hAAAA0001;
    WB_ready = 1'b0;
    next_cycle();
    check_output("bp_valid_A", 32'(valid), 32'd1);
    check_output("bp_wb_A", wb_R, 32'hAAAA0001);
    res_R = 32'hBBBB0002;
    #1;
    check_output("bp_ready_low", 32'(ready), 32'd0);
    next_cycle();
    next_cycle();
    check_output("bp_hold_valid", 32'(valid), 32'd1);
    check_output("bp_hold_wb", wb_R, 32'hAAAA0001);
    WB_ready = 1'b1;
    #1;
    check_output("bp_ready_high", 32'(ready), 32'd1);
    next_cycle();
    EX_valid = 1'b0;
    check_output("bp_valid_B", 32'(valid), 32'd1);
    check_output("bp_wb_B", wb_R, 32'hBBBB0002);
    next_cycle();
    check_output("bp_drain", 32'(valid), 32'd0);

    // Load-M with two cycles of grant delay on every beat.
    EX_valid = 1'b1;
    opcode   = 7'b0001011;
    res_R    = 32'h4000;
    res_F    = 32'h55550000;
    res_M    = {16{32'hFFFFFFFF}};
    next_cycle();
    EX_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int d = 0; d < 2; d++) begin
        #1;
        check_output($sformatf("lm_req_b%0d", k), 32'(mem_req), 32'd1);
        check_output($sformatf("lm_addr_b%0d", k), mem_addr, 32'h4000 + 32'(4 * k));
        check_output($sformatf("lm_ready_b%0d", k), 32'(ready), 32'd0);
        next_cycle();
      end
      check_output($sformatf("lm_we_b%0d", k), 32'(mem_we), 32'd0);
      mem_gnt = 1'b1;
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h100 + 32'(k);
      #1;
      check_output($sformatf("lm_valid_b%0d", k), 32'(valid), 32'd0);
      next_cycle();
      mem_rvalid = 1'b0;
    end
    check_output("lm_valid", 32'(valid), 32'd1);
    check_output("lm_wb_R", wb_R, 32'h4000);
    check_output("lm_wb_F", wb_F, 32'h55550000);
    for (int k = 0; k < 16; k++)
      check_output($sformatf("lm_wb_M%0d", k), wb_M[k*32 +: 32], 32'h100 + 32'(k));

    // Store-M interrupted by reset during the wait of beat 5.
    EX_valid = 1'b1;
    opcode   = 7'b0101011;
    res_R    = 32'h5000;
    for (int k = 0; k < 16; k++) rs2_M[k*32 +: 32] = 32'hA000 + 32'(k);
    next_cycle();
    EX_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_output($sformatf("sm_addr_b%0d", k), mem_addr, 32'h5000 + 32'(4 * k));
      check_output($sformatf("sm_wdata_b%0d", k), mem_wdata, 32'hA000 + 32'(k));
      check_output($sformatf("sm_wmask_b%0d", k), 32'(mem_wmask), 32'hF);
      check_output($sformatf("sm_we_b%0d", k), 32'(mem_we), 32'd1);
      mem_gnt = 1'b1;
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      next_cycle();
      mem_rvalid = 1'b0;
    end
    #1;
    check_output("sm_req_b5", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    rst     = 1'b0;
    #1;
    check_output("sm_rst_req", 32'(mem_req), 32'd0);
    check_output("sm_rst_valid", 32'(valid), 32'd0);
    check_output("sm_rst_wb_R", wb_R, 32'h0);
    check_output("sm_rst_addr", mem_addr, 32'h0);
    next_cycle();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_gnt    = 1'b1;
    next_cycle();
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    check_output("sm_stray_valid", 32'(valid), 32'd0);
    check_output("sm_stray_req", 32'(mem_req), 32'd0);
    next_cycle();
    check_output("sm_stray_valid2", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
